// File: rtl/vram_arbiter.sv
// Arbitrates the single async SRAM port between CPU byte accesses and VPU DMA reads.
// CPU access: WAIT+1 strobe cycles then a one-cycle cpu_ready; VPU read path is combinational.
// Backpressure: CPU is held off by withholding cpu_ready and by cpu_halt/cpu_ba; VPU via vpu_busy.
module vram_arbiter #(
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic        cpu_cs,
    output logic        cpu_ready,
    output logic        cpu_halt,
    input  logic        cpu_ba,
    input  logic [15:0] vpu_addr,
    input  logic        vpu_cs,
    input  logic        vpu_hold,
    output logic [7:0]  vpu_data,
    output logic        vpu_busy,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_di,
    output logic [7:0]  mem_do,
    output logic        mem_ce,
    output logic        mem_oe,
    output logic        mem_we
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_DONE,
        HALT_REQ,
        DMA,
        RELEASE
    } state_t;

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic [7:0]  wdat_q;
    logic        rw_q;
    logic [7:0]  cpu_do_q;
    logic [7:0]  vpu_data_q;
    logic        ready_q;
    logic        halt_q;
    logic        busy_q;

    // VPU has priority in IDLE; an access already in CPU_ACC always runs to completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (vpu_hold) begin
                    state_d = HALT_REQ;
                end else if (cpu_cs) begin
                    state_d = CPU_ACC;
                    cnt_d   = WAIT_CNT;
                end
            end
            CPU_ACC: begin
                if (cnt_q == 3'd0) begin
                    state_d = CPU_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CPU_DONE: state_d = IDLE;
            HALT_REQ: begin
                if (!vpu_hold) begin
                    state_d = IDLE;
                end else if (cpu_ba) begin
                    state_d = DMA;
                end
            end
            DMA: begin
                if (!vpu_hold) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 16'h0000;
            wdat_q     <= 8'h00;
            rw_q       <= 1'b1;
            cpu_do_q   <= 8'h00;
            vpu_data_q <= 8'h00;
            ready_q    <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && !vpu_hold && cpu_cs) begin
                addr_q <= cpu_addr;
                wdat_q <= cpu_di;
                rw_q   <= cpu_rw;
            end
            if (state_q == CPU_ACC && cnt_q == 3'd0 && rw_q) begin
                cpu_do_q <= mem_di;
            end
            if (state_q == DMA && vpu_cs) begin
                vpu_data_q <= mem_di;
            end
            ready_q <= (state_d == CPU_DONE);
            halt_q  <= (state_d == HALT_REQ) || (state_d == DMA) || (state_d == RELEASE);
            busy_q  <= (state_d != DMA);
        end
    end

    // Strobes decode state_q; CPU_DONE and RELEASE leave the bus idle for turnaround.
    always_comb begin
        mem_addr = cpu_addr;
        mem_ce   = 1'b0;
        mem_oe   = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            CPU_ACC: begin
                mem_addr = addr_q;
                mem_ce   = 1'b1;
                mem_oe   = rw_q;
                mem_we   = ~rw_q;
            end
            CPU_DONE: mem_addr = addr_q;
            DMA: begin
                mem_addr = vpu_addr;
                mem_ce   = vpu_cs;
                mem_oe   = vpu_cs;
            end
            default: mem_addr = cpu_addr;
        endcase
    end

    assign mem_do    = wdat_q;
    assign cpu_do    = cpu_do_q;
    assign cpu_ready = ready_q;
    assign cpu_halt  = halt_q;
    assign vpu_busy  = busy_q;
    assign vpu_data  = (state_q == DMA) ? mem_di : vpu_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: WAIT=1 instance on an SRAM model, WAIT=3 instance for contention.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic        cpu_rw, cpu_cs, cpu_ba;
    logic [15:0] vpu_addr;
    logic        vpu_cs, vpu_hold;
    logic        preload;

    logic [7:0]  cpu_do1, vpu_data1, mem_do1, mem_di1;
    logic        cpu_ready1, cpu_halt1, vpu_busy1, mem_ce1, mem_oe1, mem_we1;
    logic [15:0] mem_addr1;

    logic [7:0]  cpu_do3, vpu_data3, mem_do3;
    logic [7:0]  mem_di3 = 8'h00;
    logic        cpu_ready3, cpu_halt3, vpu_busy3, mem_ce3, mem_oe3, mem_we3;
    logic [15:0] mem_addr3;

    logic [7:0]  sram [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int we_viol  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.WAIT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do1), .cpu_rw(cpu_rw),
        .cpu_cs(cpu_cs), .cpu_ready(cpu_ready1), .cpu_halt(cpu_halt1), .cpu_ba(cpu_ba),
        .vpu_addr(vpu_addr), .vpu_cs(vpu_cs), .vpu_hold(vpu_hold),
        .vpu_data(vpu_data1), .vpu_busy(vpu_busy1),
        .mem_addr(mem_addr1), .mem_di(mem_di1), .mem_do(mem_do1),
        .mem_ce(mem_ce1), .mem_oe(mem_oe1), .mem_we(mem_we1)
    );

    vram_arbiter #(.WAIT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do3), .cpu_rw(cpu_rw),
        .cpu_cs(cpu_cs), .cpu_ready(cpu_ready3), .cpu_halt(cpu_halt3), .cpu_ba(cpu_ba),
        .vpu_addr(vpu_addr), .vpu_cs(vpu_cs), .vpu_hold(vpu_hold),
        .vpu_data(vpu_data3), .vpu_busy(vpu_busy3),
        .mem_addr(mem_addr3), .mem_di(mem_di3), .mem_do(mem_do3),
        .mem_ce(mem_ce3), .mem_oe(mem_oe3), .mem_we(mem_we3)
    );

    // Asynchronous SRAM model: read data visible while enabled, 0xEE otherwise.
    assign mem_di1 = (mem_ce1 && mem_oe1) ? sram[mem_addr1] : 8'hEE;

    always @(posedge clk) begin
        if (mem_ce1 && mem_we1) sram[mem_addr1] <= mem_do1;
        if (preload) begin
            for (int i = 0; i < 8; i++) sram[16'(16'h4000 + i)] <= 8'(8'h10 + i);
        end
    end

    always @(negedge clk) begin
        if ((!vpu_busy1 && mem_we1) || (!vpu_busy3 && mem_we3)) we_viol++;
    end

    typedef struct {
        logic        cs;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  di;
        logic        hold;
        logic        ba;
        logic [5:0]  exp;      // {ready, halt, busy, ce, oe, we}
        logic        chk_do;
        logic [7:0]  exp_do;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic cs, input logic rw, input logic [15:0] addr,
                                input logic [7:0] di, input logic hold, input logic ba,
                                input logic [5:0] exp, input logic chk_do, input logic [7:0] exp_do);
        vec_t v;
        v.cs = cs; v.rw = rw; v.addr = addr; v.di = di; v.hold = hold; v.ba = ba;
        v.exp = exp; v.chk_do = chk_do; v.exp_do = exp_do;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'hABCD; cpu_di = 8'h00; cpu_ba = 1'b0;
        vpu_addr = 16'h0000; vpu_cs = 1'b0; vpu_hold = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [5:0] st1();
        return {cpu_ready1, cpu_halt1, vpu_busy1, mem_ce1, mem_oe1, mem_we1};
    endfunction

    int strobes, ready_at, halt_at, busy0_at, bad;
    logic prev_rdy;

    initial begin
        preload = 1'b0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #2;
        check("reset_flags", 32'(st1()), 32'(6'b001000));
        check("reset_data", {cpu_do1, vpu_data1, mem_do1}, 32'h000000);
        check("reset_addr", 32'(mem_addr1), 32'h0000ABCD);
        rst = 1'b0;

        // Write 0x5A @0x1234, read it back, aborted hold, then write/read 0xC3 @0x0042.
        vq.push_back(mk(0, 1, 16'h0000, 8'h00, 0, 0, 6'b001000, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h1234, 8'h5A, 0, 0, 6'b001000, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h1234, 8'h5A, 0, 0, 6'b001101, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h1234, 8'h5A, 0, 0, 6'b001101, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h1234, 8'h5A, 0, 0, 6'b101000, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h1234, 8'h00, 0, 0, 6'b001000, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h1234, 8'h00, 0, 0, 6'b001000, 1, 8'h00));
        vq.push_back(mk(1, 1, 16'h1234, 8'h00, 0, 0, 6'b001110, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h1234, 8'h00, 0, 0, 6'b001110, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h1234, 8'h00, 0, 0, 6'b101000, 1, 8'h5A));
        vq.push_back(mk(0, 1, 16'h1234, 8'h00, 0, 0, 6'b001000, 1, 8'h5A));
        vq.push_back(mk(0, 1, 16'h1234, 8'h00, 1, 0, 6'b001000, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h1234, 8'h00, 1, 0, 6'b011000, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h1234, 8'h00, 0, 0, 6'b011000, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h0042, 8'hC3, 0, 0, 6'b001000, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h0042, 8'hC3, 0, 0, 6'b001101, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h0042, 8'hC3, 0, 0, 6'b001101, 0, 8'h00));
        vq.push_back(mk(1, 0, 16'h0042, 8'hC3, 0, 0, 6'b101000, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h0042, 8'h00, 0, 0, 6'b001000, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h0042, 8'h00, 0, 0, 6'b001000, 1, 8'h5A));
        vq.push_back(mk(1, 1, 16'h0042, 8'h00, 0, 0, 6'b001110, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h0042, 8'h00, 0, 0, 6'b001110, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h0042, 8'h00, 0, 0, 6'b101000, 1, 8'hC3));
        vq.push_back(mk(0, 1, 16'h0042, 8'h00, 0, 0, 6'b001000, 1, 8'hC3));

        foreach (vq[i]) begin
            tick();
            cpu_cs = vq[i].cs; cpu_rw = vq[i].rw; cpu_addr = vq[i].addr;
            cpu_di = vq[i].di; vpu_hold = vq[i].hold; cpu_ba = vq[i].ba;
            #2;
            check($sformatf("vec%0d_flags", i), 32'(st1()), 32'(vq[i].exp));
            if (vq[i].chk_do) check($sformatf("vec%0d_cpu_do", i), 32'(cpu_do1), 32'(vq[i].exp_do));
        end

        // DMA burst of 8 bytes from 0x4000 with cpu_ba tied high.
        do_reset();
        preload = 1'b1;
        tick();
        preload = 1'b0;
        cpu_ba = 1'b1;
        vpu_hold = 1'b1;
        tick();
        #2;
        check("dma_halt_req", 32'({cpu_halt1, vpu_busy1}), 32'(2'b11));
        for (int i = 0; i < 8; i++) begin
            tick();
            vpu_cs = 1'b1;
            vpu_addr = 16'(16'h4000 + i);
            #2;
            check($sformatf("dma_beat%0d", i), {7'd0, vpu_busy1, mem_addr1, vpu_data1},
                  {7'd0, 1'b0, 16'(16'h4000 + i), 8'(8'h10 + i)});
        end
        tick();
        vpu_cs = 1'b0;
        vpu_hold = 1'b0;
        tick();
        #2;
        check("dma_release", 32'({cpu_halt1, vpu_busy1, mem_ce1}), 32'(3'b110));
        tick();
        #2;
        check("dma_halt_clear", 32'({cpu_halt1, vpu_busy1}), 32'(2'b01));
        check("dma_vpu_data_held", 32'(vpu_data1), 32'h17);

        // Contention on the WAIT=3 instance: hold rises in the 2nd write strobe cycle.
        do_reset();
        cpu_ba = 1'b1;
        tick();
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h2222; cpu_di = 8'h77;
        #2;
        strobes = 0; ready_at = 0; halt_at = 0; busy0_at = 0; prev_rdy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) vpu_hold = 1'b1;
            if (prev_rdy) cpu_cs = 1'b0;
            #2;
            if (mem_ce3 && mem_we3) strobes++;
            if (cpu_ready3 && ready_at == 0) ready_at = k;
            if (cpu_halt3 && halt_at == 0) halt_at = k;
            if (!vpu_busy3 && busy0_at == 0) busy0_at = k;
            prev_rdy = cpu_ready3;
        end
        check("cont_strobes", 32'(strobes), 32'd4);
        check("cont_ready_cycle", 32'(ready_at), 32'd5);
        check("cont_halt_cycle", 32'(halt_at), 32'd7);
        check("cont_dma_cycle", 32'(busy0_at), 32'd8);
        vpu_hold = 1'b0;
        tick();
        tick();

        // Slow bus-available: cpu_ba stays low for 10 cycles in HALT_REQ.
        do_reset();
        vpu_hold = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            #2;
            if (!(vpu_busy1 && !mem_ce1 && cpu_halt1)) bad++;
        end
        check("slowba_wait", 32'(bad), 32'd0);
        tick();
        cpu_ba = 1'b1;
        #2;
        check("slowba_ba_cycle", 32'(vpu_busy1), 32'd1);
        tick();
        #2;
        check("slowba_dma", 32'(vpu_busy1), 32'd0);

        // Reset while the VPU is reading in DMA.
        tick();
        vpu_cs = 1'b1;
        vpu_addr = 16'h4003;
        #2;
        check("rstdma_active", 32'({mem_ce1, mem_oe1, vpu_busy1, vpu_data1}), {21'd0, 3'b110, 8'h13});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vpu_hold = 1'b0;
        #2;
        check("rstdma_after", 32'({mem_ce1, mem_oe1, cpu_halt1, vpu_busy1, vpu_data1}), {20'd0, 4'b0001, 8'h00});
        vpu_cs = 1'b0;
        tick();

        check("no_we_during_dma", 32'(we_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
